// File: rtl/fir_mac_filter.sv
// Time-multiplexed FIR: one signed MAC, TAPS-deep delay line, loadable coefficients; FIR_MAC_SAT_EN clamps output.
// Latency TAPS+1 cycles from accept to out_valid; in_ready/coef_ready low while busy, coef write beats sample in IDLE.
module fir_mac_filter #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 8,
  parameter int TAPS   = 4,
  parameter int SHIFT  = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     coef_wr,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]        coef_data,
  output logic                     coef_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data
);

  localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
  localparam int KW     = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;

  localparam logic signed [ACC_W:0] RND =
    (SHIFT > 0) ? (ACC_W+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0) : '0;
  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W+2-DATA_W){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                    state, state_nxt;
  logic signed [DATA_W-1:0]  x [TAPS];
  logic signed [COEF_W-1:0]  h [TAPS];
  logic signed [ACC_W-1:0]   acc;
  logic [KW-1:0]             k;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W:0]     rnd_acc;
  logic signed [ACC_W:0]     shf_acc;
  logic [DATA_W-1:0]         res;

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    coef_ready = 1'b0;
    case (state)
      IDLE: begin
        in_ready   = !coef_wr;
        coef_ready = coef_wr;
        if (in_valid && !coef_wr) state_nxt = MAC;
      end
      MAC:     if (k == KW'(TAPS - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign prod = x[k] * h[k];

  // Extra headroom bit keeps the rounding add from overflowing before the shift.
  always_comb begin
    rnd_acc = {acc[ACC_W-1], acc} + RND;
    shf_acc = rnd_acc >>> SHIFT;
`ifdef FIR_MAC_SAT_EN
    if (shf_acc > SAT_MAX)      res = SAT_MAX[DATA_W-1:0];
    else if (shf_acc < SAT_MIN) res = SAT_MIN[DATA_W-1:0];
    else                        res = shf_acc[DATA_W-1:0];
`else
    res = shf_acc[DATA_W-1:0];
`endif
  end

`ifndef FIR_MAC_SAT_EN
  logic unused_hi;
  assign unused_hi = ^{shf_acc[ACC_W:DATA_W], SAT_MAX, SAT_MIN};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      k         <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < TAPS; i++) begin
        x[i] <= '0;
        h[i] <= '0;
      end
    end else begin
      state     <= state_nxt;
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (coef_wr) begin
            if (32'(coef_addr) < TAPS) h[coef_addr] <= coef_data;
          end else if (in_valid) begin
            x[0] <= in_data;
            for (int i = TAPS - 1; i > 0; i--) x[i] <= x[i-1];
            acc <= '0;
            k   <= '0;
          end
        end
        MAC: begin
          acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
          k   <= k + KW'(1);
        end
        DONE: begin
          out_data  <= res;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_filter.sv
// Bench: two filter instances (TAPS=4/SHIFT=0 and TAPS=5/SHIFT=2) behind a select mux,
// directed and random samples checked against a dot-product reference model.
module tb_fir_mac_filter;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        in_valid;
  logic [15:0] in_data;
  logic        coef_wr;
  logic [2:0]  coef_addr;
  logic [7:0]  coef_data;

  logic        a_in_ready, a_coef_ready, a_out_valid;
  logic [15:0] a_out_data;
  logic        b_in_ready, b_coef_ready, b_out_valid;
  logic [15:0] b_out_data;
  logic        a_in_valid, b_in_valid, a_coef_wr, b_coef_wr;
  logic [1:0]  a_coef_addr;

  logic        m_in_ready, m_coef_ready, m_out_valid;
  logic [15:0] m_out_data;

  int checks = 0;
  int errors = 0;
  int hist [2][8];
  int coef [2][8];

  always #5 clk = ~clk;

  assign a_in_valid  = in_valid & ~sel;
  assign b_in_valid  = in_valid & sel;
  assign a_coef_wr   = coef_wr & ~sel;
  assign b_coef_wr   = coef_wr & sel;
  assign a_coef_addr = coef_addr[1:0];
  assign m_in_ready   = sel ? b_in_ready   : a_in_ready;
  assign m_coef_ready = sel ? b_coef_ready : a_coef_ready;
  assign m_out_valid  = sel ? b_out_valid  : a_out_valid;
  assign m_out_data   = sel ? b_out_data   : a_out_data;

  fir_mac_filter #(.DATA_W(16), .COEF_W(8), .TAPS(4), .SHIFT(0)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .coef_wr(a_coef_wr), .coef_addr(a_coef_addr),
    .coef_data(coef_data), .coef_ready(a_coef_ready),
    .out_valid(a_out_valid), .out_data(a_out_data));

  fir_mac_filter #(.DATA_W(16), .COEF_W(8), .TAPS(5), .SHIFT(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .coef_wr(b_coef_wr), .coef_addr(coef_addr),
    .coef_data(coef_data), .coef_ready(b_coef_ready),
    .out_valid(b_out_valid), .out_data(b_out_data));

  function automatic int taps_f(input logic s);
    return s ? 5 : 4;
  endfunction

  function automatic int shift_f(input logic s);
    return s ? 2 : 0;
  endfunction

  function automatic longint model_out(input logic s);
    longint acc;
    logic signed [15:0] w;
    acc = 0;
    for (int i = 0; i < taps_f(s); i++) acc += longint'(hist[s][i]) * longint'(coef[s][i]);
    if (shift_f(s) > 0) acc += longint'(1) << (shift_f(s) - 1);
    acc = acc >>> shift_f(s);
`ifdef FIR_MAC_SAT_EN
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc;
`else
    w = acc[15:0];
    return longint'(w);
`endif
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 8; i++) begin
        hist[s][i] = 0;
        coef[s][i] = 0;
      end
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called and returns at negedge+1; the write lands on the next rising edge.
  task automatic write_coef(input int a, input int v);
    coef_wr   = 1'b1;
    coef_addr = a[2:0];
    coef_data = v[7:0];
    #1;
    check("coef_ready_idle", m_coef_ready, 1);
    check("in_ready_during_wr", m_in_ready, 0);
    if (a < taps_f(sel)) coef[sel][a] = v;
    @(negedge clk);
    coef_wr = 1'b0;
    #1;
  endtask

  task automatic send_sample(input int d, input bit hold, input bit busy_wr, input bit abort,
                             output longint got);
    longint exp;
    int n;
    n = taps_f(sel) + 2;
    in_valid = 1'b1;
    in_data  = d[15:0];
    #1;
    check("in_ready_idle", m_in_ready, 1);
    for (int i = taps_f(sel) - 1; i > 0; i--) hist[sel][i] = hist[sel][i-1];
    hist[sel][0] = d;
    exp = model_out(sel);
    for (int i = 1; i <= (abort ? n + 2 : n); i++) begin
      @(negedge clk);
      if (i == 1 && !hold) in_valid = 1'b0;
      if (busy_wr && i == 2) begin
        coef_wr = 1'b1; coef_addr = 3'd0; coef_data = 8'd55;
      end
      if (busy_wr && i == 3) coef_wr = 1'b0;
      if (abort && i == 2) begin
        reset = 1'b1;
        model_reset();
      end
      if (abort && i == 3) reset = 1'b0;
      #1;
      if (!abort && i < n) check("busy_in_ready", m_in_ready, 0);
      if (busy_wr && i == 2) check("busy_coef_ready", m_coef_ready, 0);
      check("out_valid_timing", m_out_valid, (!abort && i == n));
    end
    if (!abort) check("out_data_model", $signed(m_out_data), exp);
    else        check("in_ready_after_reset", m_in_ready, 1);
    got = $signed(m_out_data);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    longint got;
    int imp_in  [5] = '{1, 0, 0, 0, 0};
    int imp_exp [5] = '{13, -16, 19, -21, 0};
    int sat_exp;
    int v;

    reset = 1'b1; sel = 1'b0; in_valid = 1'b0; in_data = '0;
    coef_wr = 1'b0; coef_addr = '0; coef_data = '0;
    model_reset();
    @(negedge clk); #1;
    check("reset_in_ready", m_in_ready, 1);
    check("reset_out_valid", m_out_valid, 0);
    check("reset_out_data", $signed(m_out_data), 0);
    check("reset_coef_ready", m_coef_ready, 0);
    reset = 1'b0;
    @(negedge clk); #1;

    // Impulse response
    write_coef(0, 13); write_coef(1, -16); write_coef(2, 19); write_coef(3, -21);
    for (int i = 0; i < 5; i++) begin
      send_sample(imp_in[i], 0, 0, 0, got);
      check("impulse", got, imp_exp[i]);
    end

    // Coefficient write beats a sample in the same IDLE cycle
    coef_wr = 1'b1; coef_addr = 3'd0; coef_data = 8'd2;
    in_valid = 1'b1; in_data = 16'd5;
    #1;
    check("prio_coef_ready", m_coef_ready, 1);
    check("prio_in_ready", m_in_ready, 0);
    coef[0][0] = 2;
    @(negedge clk);
    coef_wr = 1'b0;
    send_sample(5, 0, 1, 0, got);
    check("prio_sample", got, 10);
    send_sample(0, 0, 0, 0, got);
    check("after_prio", got, -80);
    send_sample(1, 0, 0, 0, got);
    check("busy_wr_dropped", got, 97);

    // Back-to-back with held valid
    for (int i = 0; i < 4; i++) write_coef(i, 1);
    for (int i = 0; i < 4; i++) send_sample(0, 0, 0, 0, got);
    send_sample(1, 1, 0, 0, got); check("b2b_0", got, 1);
    send_sample(2, 1, 0, 0, got); check("b2b_1", got, 3);
    send_sample(3, 0, 0, 0, got); check("b2b_2", got, 6);

    // Saturation / wrap
    for (int i = 0; i < 4; i++) write_coef(i, 127);
    for (int i = 0; i < 4; i++) send_sample(32767, 0, 0, 0, got);
`ifdef FIR_MAC_SAT_EN
    sat_exp = 32767;
`else
    sat_exp = -508;
`endif
    check("saturation", got, sat_exp);

    // Reset during the second MAC cycle
    send_sample(7, 0, 0, 1, got);
    send_sample(100, 0, 0, 0, got);
    check("post_reset_zero_coef", got, 0);

    // Random traffic, instance A
    for (int i = 0; i < 4; i++) write_coef(i, int'($urandom_range(0, 255)) - 128);
    for (int i = 0; i < 12; i++) begin
      v = int'($urandom_range(0, 65535)) - 32768;
      send_sample(v, i[0], 0, 0, got);
    end
    send_sample(0, 0, 0, 0, got);

    // Instance B: rounding and out-of-range address
    sel = 1'b1;
    #1;
    write_coef(0, 1);
    write_coef(7, 99);
    send_sample(6, 0, 0, 0, got);
    check("round_pos", got, 2);
    send_sample(-6, 0, 0, 0, got);
    check("round_neg", got, -1);
    for (int i = 0; i < 5; i++) write_coef(i, int'($urandom_range(0, 255)) - 128);
    for (int i = 0; i < 12; i++) begin
      v = int'($urandom_range(0, 65535)) - 32768;
      send_sample(v, 0, 0, 0, got);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
